// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter
// Round-robin arbiter that funnels NUM_SLAVE_PORTS AXI-Lite requesters onto a
// single AXI-Lite master port. Exactly one transaction is in flight at a time,
// so responses are routed back using the registered grant alone.
// Requester ports are flattened: port i uses bit i of 1-bit signals and slice
// [i*W +: W] of W-bit signals.

module axil_master_arbiter #(
  parameter int NUM_SLAVE_PORTS = 4
) (
  input  logic                            aclk,
  input  logic                            areset,

  // requester side
  input  logic [NUM_SLAVE_PORTS-1:0]      s_awvalid,
  output logic [NUM_SLAVE_PORTS-1:0]      s_awready,
  input  logic [NUM_SLAVE_PORTS*32-1:0]   s_awaddr,
  input  logic [NUM_SLAVE_PORTS-1:0]      s_wvalid,
  output logic [NUM_SLAVE_PORTS-1:0]      s_wready,
  input  logic [NUM_SLAVE_PORTS*32-1:0]   s_wdata,
  input  logic [NUM_SLAVE_PORTS*4-1:0]    s_wstrb,
  output logic [NUM_SLAVE_PORTS-1:0]      s_bvalid,
  input  logic [NUM_SLAVE_PORTS-1:0]      s_bready,
  output logic [NUM_SLAVE_PORTS*2-1:0]    s_bresp,
  input  logic [NUM_SLAVE_PORTS-1:0]      s_arvalid,
  output logic [NUM_SLAVE_PORTS-1:0]      s_arready,
  input  logic [NUM_SLAVE_PORTS*32-1:0]   s_araddr,
  output logic [NUM_SLAVE_PORTS-1:0]      s_rvalid,
  input  logic [NUM_SLAVE_PORTS-1:0]      s_rready,
  output logic [NUM_SLAVE_PORTS*32-1:0]   s_rdata,
  output logic [NUM_SLAVE_PORTS*2-1:0]    s_rresp,

  // shared port toward the crossbar
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [31:0]                     m_awaddr,
  output logic [2:0]                      m_awprot,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  output logic [31:0]                     m_wdata,
  output logic [3:0]                      m_wstrb,
  input  logic                            m_bvalid,
  output logic                            m_bready,
  input  logic [1:0]                      m_bresp,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  output logic [31:0]                     m_araddr,
  output logic [2:0]                      m_arprot,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  input  logic [31:0]                     m_rdata,
  input  logic [1:0]                      m_rresp
);

  localparam int N  = NUM_SLAVE_PORTS;
  localparam int PW = $clog2(N);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] grant;
  logic [PW-1:0] rr_ptr;
  logic          last_was_write;
  logic          aw_done;
  logic          w_done;

  logic [N-1:0]  wreq;
  logic [N-1:0]  rreq;
  logic [N-1:0]  req;
  logic [N-1:0]  gsel;
  logic [PW-1:0] pick;
  logic          pick_write;
  logic [PW-1:0] rr_next;
  logic          aw_done_nxt;
  logic          w_done_nxt;

  logic [31:0]   awaddr_a [N];
  logic [31:0]   wdata_a  [N];
  logic [3:0]    wstrb_a  [N];
  logic [31:0]   araddr_a [N];

  // First requesting port at or after ptr, walking upward modulo N. The scan
  // runs from the farthest offset down so the nearest hit is written last.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [PW-1:0] ptr);
    logic [PW-1:0] sel;
    logic [PW-1:0] cand;
    int            idx;
    sel = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      idx  = (int'(ptr) + k) % N;
      cand = idx[PW-1:0];
      if (r[cand]) sel = cand;
    end
    return sel;
  endfunction

  assign wreq = s_awvalid & s_wvalid;
  assign rreq = s_arvalid;
  assign req  = wreq | rreq;

  assign pick       = rr_pick(req, rr_ptr);
  assign pick_write = wreq[pick] & (~rreq[pick] | ~last_was_write);
  assign rr_next    = (grant == PW'(N - 1)) ? '0 : grant + PW'(1);

  assign aw_done_nxt = aw_done | (m_awvalid & m_awready);
  assign w_done_nxt  = w_done  | (m_wvalid  & m_wready);

  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

  for (genvar i = 0; i < N; i++) begin : g_port
    assign awaddr_a[i] = s_awaddr[i*32 +: 32];
    assign wdata_a[i]  = s_wdata[i*32 +: 32];
    assign wstrb_a[i]  = s_wstrb[i*4 +: 4];
    assign araddr_a[i] = s_araddr[i*32 +: 32];
    assign gsel[i]     = (grant == PW'(i));

    // Response data reaches only the granted port, and only in its response state.
    assign s_bresp[i*2 +: 2]  = (gsel[i] && state == WR_RESP) ? m_bresp : 2'b00;
    assign s_rdata[i*32 +: 32] = (gsel[i] && state == RD_RESP) ? m_rdata : 32'h0;
    assign s_rresp[i*2 +: 2]  = (gsel[i] && state == RD_RESP) ? m_rresp : 2'b00;
  end

  assign s_awready = gsel & {N{(state == WR_REQ)  & m_awready & ~aw_done}};
  assign s_wready  = gsel & {N{(state == WR_REQ)  & m_wready  & ~w_done}};
  assign s_bvalid  = gsel & {N{(state == WR_RESP) & m_bvalid}};
  assign s_arready = gsel & {N{(state == RD_REQ)  & m_arready}};
  assign s_rvalid  = gsel & {N{(state == RD_RESP) & m_rvalid}};

  // Master-side request/response mux driven by the registered grant.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    m_awvalid = 1'b0;
    m_awaddr  = 32'h0;
    m_wvalid  = 1'b0;
    m_wdata   = 32'h0;
    m_wstrb   = 4'h0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_araddr  = 32'h0;
    m_rready  = 1'b0;
    case (state)
      WR_REQ: begin
        m_awvalid = s_awvalid[grant] & ~aw_done;
        m_awaddr  = awaddr_a[grant];
        m_wvalid  = s_wvalid[grant] & ~w_done;
        m_wdata   = wdata_a[grant];
        m_wstrb   = wstrb_a[grant];
      end
      WR_RESP: m_bready = s_bready[grant];
      RD_REQ: begin
        m_arvalid = s_arvalid[grant];
        m_araddr  = araddr_a[grant];
      end
      RD_RESP: m_rready = s_rready[grant];
      default: ;
    endcase
  end

  // Transaction FSM, grant/op capture and round-robin pointer update.
  always_ff @(posedge aclk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (areset) begin
      state          <= IDLE;
      grant          <= '0;
      rr_ptr         <= '0;
      last_was_write <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant          <= pick;
            last_was_write <= pick_write;
            state          <= pick_write ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ: begin
          // AW and W complete independently; leave once both have happened.
          if (aw_done_nxt && w_done_nxt) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
          end
        end
        WR_RESP: begin
          if (m_bvalid && m_bready) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
          end
        end
        RD_REQ: begin
          if (m_arvalid && m_arready) state <= RD_RESP;
        end
        RD_RESP: begin
          if (m_rvalid && m_rready) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// tb_axil_master_arbiter
// Scenario tasks drive requesters and act as the downstream slave. Expected
// responses are queued when a transaction is launched and popped when a
// response handshake appears on a requester port.

module tb_axil_master_arbiter;

  localparam int N = 4;

  logic              aclk = 1'b0;
  logic              areset;

  logic [N-1:0]      s_awvalid, s_awready;
  logic [N*32-1:0]   s_awaddr;
  logic [N-1:0]      s_wvalid, s_wready;
  logic [N*32-1:0]   s_wdata;
  logic [N*4-1:0]    s_wstrb;
  logic [N-1:0]      s_bvalid, s_bready;
  logic [N*2-1:0]    s_bresp;
  logic [N-1:0]      s_arvalid, s_arready;
  logic [N*32-1:0]   s_araddr;
  logic [N-1:0]      s_rvalid, s_rready;
  logic [N*32-1:0]   s_rdata;
  logic [N*2-1:0]    s_rresp;

  logic              m_awvalid, m_awready;
  logic [31:0]       m_awaddr;
  logic [2:0]        m_awprot;
  logic              m_wvalid, m_wready;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_bvalid, m_bready;
  logic [1:0]        m_bresp;
  logic              m_arvalid, m_arready;
  logic [31:0]       m_araddr;
  logic [2:0]        m_arprot;
  logic              m_rvalid, m_rready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;

  axil_master_arbiter #(.NUM_SLAVE_PORTS(N)) dut (
    .aclk(aclk), .areset(areset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          port;
    bit          is_write;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic any_out();
    return |{s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
             m_awvalid, m_awaddr, m_awprot, m_wvalid, m_wdata, m_wstrb, m_bready,
             m_arvalid, m_araddr, m_arprot, m_rready};
  endfunction

  // Pop the oldest expected response and compare it with what a port received.
  task automatic sb_pop(input int port, input bit is_write, input logic [31:0] data,
                        input logic [1:0] resp);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected_resp port=%0d wr=%0d (no response expected)", port, is_write);
    end else begin
      e = exp_q.pop_front();
      if (e.port !== port || e.is_write !== is_write || e.resp !== resp ||
          (!is_write && e.data !== data)) begin
        errors++;
        $display("FAIL sb_resp got port=%0d wr=%0d data=%h resp=%0d, expected port=%0d wr=%0d data=%h resp=%0d",
                 port, is_write, data, resp, e.port, e.is_write, e.data, e.resp);
      end
    end
  endtask

  // Let inputs settle, harvest response handshakes, then advance one cycle.
  task automatic step();
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_bvalid[i] && s_bready[i]) sb_pop(i, 1'b1, 32'h0, s_bresp[i*2 +: 2]);
      if (s_rvalid[i] && s_rready[i]) sb_pop(i, 1'b0, s_rdata[i*32 +: 32], s_rresp[i*2 +: 2]);
    end
    @(posedge aclk);
    #2;
  endtask

  task automatic clear_inputs();
    s_awvalid = '0; s_awaddr = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0;
    s_bready = '0; s_arvalid = '0; s_araddr = '0; s_rready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
  endtask

  task automatic apply_reset();
    clear_inputs();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st);
    s_awvalid[p] = 1'b1; s_awaddr[p*32 +: 32] = a;
    s_wvalid[p]  = 1'b1; s_wdata[p*32 +: 32]  = d; s_wstrb[p*4 +: 4] = st;
  endtask

  task automatic clr_wr(input int p);
    s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [31:0] a);
    s_arvalid[p] = 1'b1; s_araddr[p*32 +: 32] = a;
  endtask

  task automatic clr_rd(input int p);
    s_arvalid[p] = 1'b0;
  endtask

  // One write for port p, entered in IDLE with the request already driven.
  // The downstream raises awready after aw_lat cycles and wready after w_lat.
  task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int aw_lat, input int w_lat,
                          input logic [1:0] resp, input int exp_rr);
    exp_t e;
    int   aw_hs = 0;
    int   w_hs  = 0;
    e = '{port: p, is_write: 1'b1, data: d, resp: resp};
    exp_q.push_back(e);
    s_bready[p] = 1'b1;
    step();
    checks++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1) begin
      errors++;
      $display("FAIL wr_latency port=%0d awvalid=%b wvalid=%b, expected 1 1", p, m_awvalid, m_wvalid);
    end
    for (int c = 0; c < 12 && !(aw_hs > 0 && w_hs > 0); c++) begin
      m_awready = (c >= aw_lat);
      m_wready  = (c >= w_lat);
      #1;
      checks++;
      if (m_bready !== 1'b0) begin
        errors++;
        $display("FAIL wr_early_resp port=%0d cycle=%0d bready=%b, expected 0", p, c, m_bready);
      end
      if (m_awvalid && m_awready) begin
        aw_hs++;
        checks++;
        if (m_awaddr !== a || s_awready !== (4'b0001 << p)) begin
          errors++;
          $display("FAIL aw_chan addr=%h awready=%b, expected addr=%h awready=%b",
                   m_awaddr, s_awready, a, 4'b0001 << p);
        end
      end
      if (m_wvalid && m_wready) begin
        w_hs++;
        checks++;
        if (m_wdata !== d || m_wstrb !== st || s_wready !== (4'b0001 << p)) begin
          errors++;
          $display("FAIL w_chan data=%h strb=%h wready=%b, expected data=%h strb=%h wready=%b",
                   m_wdata, m_wstrb, s_wready, d, st, 4'b0001 << p);
        end
      end
      step();
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    checks++;
    if (aw_hs !== 1 || w_hs !== 1) begin
      errors++;
      $display("FAIL wr_handshakes aw=%0d w=%0d, expected 1 1", aw_hs, w_hs);
    end
    clr_wr(p);
    m_bvalid = 1'b1;
    m_bresp  = resp;
    #1;
    checks++;
    if (s_bvalid !== (4'b0001 << p) || m_bready !== 1'b1 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_resp bvalid=%b bready=%b awvalid=%b wvalid=%b, expected bvalid=%b 1 0 0",
               s_bvalid, m_bready, m_awvalid, m_wvalid, 4'b0001 << p);
    end
    step();
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    checks++;
    if (dut.rr_ptr !== 2'(exp_rr)) begin
      errors++;
      $display("FAIL wr_rr_ptr got=%0d expected=%0d", dut.rr_ptr, exp_rr);
    end
  endtask

  // One read for port p, entered in IDLE with arvalid already driven. The
  // requester holds rready low for hold cycles once rvalid is offered.
  task automatic do_read(input int p, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] resp, input int hold, input int exp_rr);
    exp_t e;
    e = '{port: p, is_write: 1'b0, data: d, resp: resp};
    exp_q.push_back(e);
    s_rready[p] = (hold == 0);
    step();
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== a || m_awvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_req port=%0d arvalid=%b araddr=%h awvalid=%b, expected 1 %h 0",
               p, m_arvalid, m_araddr, m_awvalid, a);
    end
    m_arready = 1'b1;
    #1;
    checks++;
    if (s_arready !== (4'b0001 << p)) begin
      errors++;
      $display("FAIL rd_arready got=%b expected=%b", s_arready, 4'b0001 << p);
    end
    step();
    m_arready = 1'b0;
    clr_rd(p);
    m_rvalid = 1'b1;
    m_rdata  = d;
    m_rresp  = resp;
    for (int c = 0; c < hold; c++) begin
      #1;
      checks++;
      if (m_rready !== 1'b0 || s_rvalid !== (4'b0001 << p) || s_rresp[p*2 +: 2] !== resp ||
          m_arvalid !== 1'b0 || m_awvalid !== 1'b0 || s_arready !== 4'b0000) begin
        errors++;
        $display("FAIL rd_backpressure cycle=%0d rready=%b rvalid=%b rresp=%0d arvalid=%b awvalid=%b, expected 0 %b %0d 0 0",
                 c, m_rready, s_rvalid, s_rresp[p*2 +: 2], m_arvalid, m_awvalid, 4'b0001 << p, resp);
      end
      step();
    end
    s_rready[p] = 1'b1;
    #1;
    checks++;
    if (m_rready !== 1'b1 || s_rvalid !== (4'b0001 << p) || s_rdata[p*32 +: 32] !== d) begin
      errors++;
      $display("FAIL rd_resp rready=%b rvalid=%b rdata=%h, expected 1 %b %h",
               m_rready, s_rvalid, s_rdata[p*32 +: 32], 4'b0001 << p, d);
    end
    step();
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    m_rresp  = 2'b00;
    checks++;
    if (dut.rr_ptr !== 2'(exp_rr)) begin
      errors++;
      $display("FAIL rd_rr_ptr got=%0d expected=%0d", dut.rr_ptr, exp_rr);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    areset = 1'b1;
    set_rd(0, 32'h0000_0050);
    step();
    step();
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs some output nonzero during reset, expected all 0");
    end
    clr_rd(0);
    areset = 1'b0;
    step();
    checks++;
    if (any_out() !== 1'b0 || dut.rr_ptr !== 2'd0 || dut.last_was_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_state any_out=%b rr_ptr=%0d last_was_write=%b, expected 0 0 0",
               any_out(), dut.rr_ptr, dut.last_was_write);
    end
  endtask

  task automatic test_single_write();
    set_wr(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valids awvalid=%b wvalid=%b, expected 0 0", m_awvalid, m_wvalid);
    end
    do_write(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 1);
  endtask

  task automatic test_contention();
    apply_reset();
    set_rd(0, 32'h0000_0100);
    set_rd(1, 32'h0000_0104);
    set_rd(3, 32'h0000_010C);
    do_read(0, 32'h0000_0100, 32'hA000_0000, 2'b00, 0, 1);
    do_read(1, 32'h0000_0104, 32'hA000_0001, 2'b00, 0, 2);
    do_read(3, 32'h0000_010C, 32'hA000_0003, 2'b00, 0, 0);
    checks++;
    if (s_rdata[2*32 +: 32] !== 32'h0 || s_rvalid[2] !== 1'b0 || s_arready[2] !== 1'b0) begin
      errors++;
      $display("FAIL port2_quiet rdata=%h rvalid=%b arready=%b, expected 0 0 0",
               s_rdata[2*32 +: 32], s_rvalid[2], s_arready[2]);
    end
  endtask

  task automatic test_split_aw_w();
    set_wr(2, 32'h0000_0A00, 32'h0123_4567, 4'hC);
    do_write(2, 32'h0000_0A00, 32'h0123_4567, 4'hC, 3, 0, 2'b00, 3);
  endtask

  task automatic test_same_port();
    apply_reset();
    set_wr(1, 32'h0000_0020, 32'h1234_5678, 4'h3);
    set_rd(1, 32'h0000_0024);
    do_write(1, 32'h0000_0020, 32'h1234_5678, 4'h3, 0, 0, 2'b00, 2);
    do_read(1, 32'h0000_0024, 32'hCAFE_0001, 2'b00, 0, 2);
  endtask

  task automatic test_backpressure();
    // rr_ptr is 2 here, so port 2 wins and port 0 waits behind it.
    set_rd(2, 32'h0000_0200);
    set_rd(0, 32'h0000_0300);
    do_read(2, 32'h0000_0200, 32'h0BAD_F00D, 2'b10, 5, 3);
    do_read(0, 32'h0000_0300, 32'h0000_600D, 2'b00, 0, 1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_wr(1, 32'h0000_0040, 32'h5555_AAAA, 4'hF);
    s_bready[1] = 1'b1;
    step();
    m_awready = 1'b1;
    m_wready  = 1'b0;
    step();
    m_awready = 1'b0;
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_aw_done awvalid=%b wvalid=%b, expected 0 1", m_awvalid, m_wvalid);
    end
    areset = 1'b1;
    step();
    checks++;
    if (any_out() !== 1'b0 || dut.rr_ptr !== 2'd0 || dut.aw_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset any_out=%b rr_ptr=%0d aw_done=%b, expected 0 0 0",
               any_out(), dut.rr_ptr, dut.aw_done);
    end
    areset = 1'b0;
    clr_wr(1);
    set_rd(1, 32'h0000_0044);
    do_read(1, 32'h0000_0044, 32'h7777_0000, 2'b00, 0, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_split_aw_w();
    test_same_port();
    test_backpressure();
    test_reset_mid();
    step();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
